// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Iterative multiply/divide unit for the MIPS32 execute stage. Holds the
//   architectural HI/LO registers and implements MULT, MULTU, DIV, DIVU,
//   MTHI and MTLO. Multiply and divide take 32 iteration cycles plus one
//   sign-fix cycle; MTHI/MTLO write HI/LO on the accept edge.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : begin the operation selected by op (only sampled in IDLE)
//   op     : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//            110/111 no-op
//   a      : rs operand (multiplicand, dividend, MTHI/MTLO source)
//   b      : rt operand (multiplier, divisor)
//   busy   : high while a multiply/divide is in progress
//   done   : one-cycle pulse after HI/LO were written by a multiply/divide
//   hi, lo : HI and LO registers
// -----------------------------------------------------------------------------
module mul_div_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic        is_div;
   logic        sign_a;
   logic        sign_b;
   logic [31:0] opnd;   // multiplicand magnitude, or divisor magnitude
   logic [63:0] prod;   // multiply: {partial sum, remaining multiplier bits}
   logic [31:0] rem;    // divide: remainder so far
   logic [31:0] quo;    // divide: dividend bits still to consume / quotient bits

   // Operand magnitudes at accept time. Even op codes are the signed
   // variants; negating 0x80000000 yields 0x80000000, which is exactly the
   // unsigned magnitude wanted.
   logic        signed_op;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] abs_a;
   logic [31:0] abs_b;

   assign signed_op = ~op[0];
   assign a_neg     = signed_op & a[31];
   assign b_neg     = signed_op & b[31];
   assign abs_a     = a_neg ? (~a + 32'd1) : a;
   assign abs_b     = b_neg ? (~b + 32'd1) : b;

   // Multiply step: add the multiplicand when the current multiplier bit
   // (LSB of prod) is set, then shift the whole 64-bit product right by one.
   logic [32:0] mul_sum;
   assign mul_sum = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);

   // Divide step: the 33-bit partial remainder brings in the next dividend
   // bit, MSB first. The subtraction is kept only when it does not underflow.
   // The retained difference is always below the divisor, so 32 bits hold it.
   logic [32:0] div_shift;
   logic        div_ok;
   logic [31:0] div_diff;
   assign div_shift = {rem, quo[31]};
   assign div_ok    = (div_shift >= {1'b0, opnd});
   assign div_diff  = div_shift[31:0] - opnd;

   // Sign fix applied on the FIX edge.
   logic        res_neg;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   assign res_neg  = sign_a ^ sign_b;
   assign prod_fix = res_neg ? (~prod + 64'd1) : prod;
   assign quo_fix  = res_neg ? (~quo + 32'd1) : quo;
   assign rem_fix  = sign_a ? (~rem + 32'd1) : rem;

   // NOTE: non-blocking assignments throughout so every register samples the
   // pre-edge value of every other register, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the work registers are reset as well as the control state;
         // they are only a few flops, and known values keep simulation free
         // of X that would otherwise leak into hi/lo on an aborted sequence.
         state  <= S_IDLE;
         cnt    <= 5'd0;
         is_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         opnd   <= 32'd0;
         prod   <= 64'd0;
         rem    <= 32'd0;
         quo    <= 32'd0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= 32'd0;
         lo     <= 32'd0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MTHI: hi <= a;
                     OP_MTLO: lo <= a;
                     OP_MULT, OP_MULTU: begin
                        state  <= S_RUN;
                        busy   <= 1'b1;
                        cnt    <= 5'd0;
                        is_div <= 1'b0;
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        opnd   <= abs_a;
                        prod   <= {32'd0, abs_b};
                     end
                     OP_DIV, OP_DIVU: begin
                        state  <= S_RUN;
                        busy   <= 1'b1;
                        cnt    <= 5'd0;
                        is_div <= 1'b1;
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        opnd   <= abs_b;
                        quo    <= abs_a;
                        rem    <= 32'd0;
                     end
                     default: ;  // 110/111 are no-ops
                  endcase
               end
            end

            S_RUN: begin
               if (is_div) begin
                  rem <= div_ok ? div_diff : div_shift[31:0];
                  quo <= {quo[30:0], div_ok};
               end else begin
                  prod <= {mul_sum, prod[31:1]};
               end
               if (cnt == 5'd31) begin
                  state <= S_FIX;
                  cnt   <= 5'd0;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end

            S_FIX: begin
               if (is_div) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[63:32];
                  lo <= prod_fix[31:0];
               end
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the MIPS32 Harvard CPU execute stage, sitting beside the ALU and consuming the same rs/rt operands. Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers read by MFHI/MFLO. Multi-cycle operations use a start/busy/done handshake so the control unit can stall while the result is computed.

## Interface
- No parameters; the datapath width is fixed at 32 bits.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin the operation on `op`; sampled only in IDLE.
- op  input  3  operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
- a  input  32  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- b  input  32  rt operand: multiplier or divisor.
- busy  output  1  high while a multi-cycle operation is in progress.
- done  output  1  one-cycle pulse when HI/LO have just been updated by a multi-cycle operation.
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- **States:** IDLE, RUN, FIX.
- **Reset:** `rst_n` low asynchronously forces the following, aborting any operation in progress with no partial result kept:
  - state = IDLE
  - hi = 0, lo = 0
  - busy = 0, done = 0
  - iteration counter = 0
- **IDLE, start=1, op=MTHI:** hi <= a at the same edge. No busy, no done, state stays IDLE.
- **IDLE, start=1, op=MTLO:** lo <= a at the same edge. No busy, no done, state stays IDLE.
- **IDLE, start=1, op=110/111:** ignored.
- **IDLE, start=1, MULT/MULTU/DIV/DIVU:**
  - Latch operand magnitudes, sign flags and the op code; go to RUN; busy=1.
  - Signed ops take |a| and |b| in two's complement; |0x80000000| = 0x80000000 as an unsigned 32-bit magnitude.
  - Unsigned ops use a and b as-is, with sign flags forced to 0.
- **RUN:** 32 iterations, one per cycle, with a 5-bit counter running 0..31.
  - Multiply: shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first, with a 33-bit partial remainder.
  - After the iteration with counter=31, go to FIX.
- **FIX:** apply signs and write HI/LO, then go to IDLE with busy=0 and done=1 for one cycle.
  - Multiply: if sign(a) XOR sign(b), negate the 64-bit product. hi = product[63:32], lo = product[31:0].
  - Divide: lo = quotient, negated if sign(a) XOR sign(b). hi = remainder, negated if sign(a).
- **Divide by zero:** no trap and no early exit; latency is unchanged. Required result, which restoring division on magnitudes produces naturally before sign fix:
  - DIVU: lo = 0xFFFFFFFF, hi = a.
  - DIV: the FIX rules applied to quotient 0xFFFFFFFF and remainder |a|.
- **DIV 0x80000000 / 0xFFFFFFFF:** lo = 0x80000000, hi = 0.
- **start while busy:** ignored for every op, including MTHI/MTLO. The control unit must stall instead.
- **hi/lo stability:** hi and lo hold their previous values throughout RUN and FIX until the FIX edge.

## Timing
- **Accept edge E0:** start is sampled in IDLE; busy is high after E0.
- **RUN:** iterations occur on edges E1..E32.
- **FIX edge E33:** hi/lo update, busy falls, done rises.
- **done:** high during the cycle after E33 only.
- **Latency:** results are visible 33 cycles after the accept edge.
- **Back-to-back:** a new start is accepted at E34 if asserted while done=1, since the state is IDLE in that cycle.
- **MTHI/MTLO:** zero extra latency; hi or lo is visible the cycle after the accept edge.
- **Operand changes:** a and b may change after E0 without affecting the result.

## Test plan
- **Reset:** hold rst_n=0, then release -> hi=0, lo=0, busy=0, done=0. Assert rst_n low at E10 of a MULT -> all outputs 0 immediately, state IDLE, and no done pulse follows.
- **MULT:**
  - a=7, b=6 -> at E33, hi=0x00000000, lo=0x0000002A, done pulses once, busy high for exactly 33 cycles.
  - a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- **MULTU:** a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- **DIV and divide-by-zero:**
  - DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- **MTHI/MTLO and start-while-busy:**
  - MTHI a=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy/done stay 0.
  - MTLO issued during a DIVU -> ignored; lo equals the DIVU quotient after FIX.
  - start with op=111 -> no state change.
- **Back-to-back:** 10000 random MULTU/DIVU pairs with start asserted on each done cycle -> every result matches a 64-bit reference model; remainder < divisor whenever b != 0.
